// File: rtl/fifo_ctrl.sv
// FIFO control block: grants producer/consumer requests, tracks pointers and occupancy,
// and reports status plus sticky overflow/underflow errors for an external memory.
module fifo_ctrl #(
    parameter int MEMORY_DEPTH = 4,
    parameter int ADDRESS_SIZE = 2,
    parameter int AF_LEVEL     = MEMORY_DEPTH - 1,
    parameter int AE_LEVEL     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_req,
    input  logic                    rd_req,
    input  logic                    clr_err,
    output logic                    cw_en,
    output logic                    cr_en,
    output logic [ADDRESS_SIZE-1:0] w_ptr,
    output logic [ADDRESS_SIZE-1:0] r_ptr,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic                    underflow
);

    typedef enum logic [1:0] {S_EMPTY, S_PART, S_FULL} state_t;

    localparam logic [ADDRESS_SIZE-1:0] LAST_PTR  = ADDRESS_SIZE'(MEMORY_DEPTH - 1);
    localparam logic [ADDRESS_SIZE:0]   DEPTH_M1  = (ADDRESS_SIZE + 1)'(MEMORY_DEPTH - 1);
    localparam logic [ADDRESS_SIZE:0]   ONE_CNT   = (ADDRESS_SIZE + 1)'(1);
    localparam logic [ADDRESS_SIZE:0]   AF_CNT    = (ADDRESS_SIZE + 1)'(AF_LEVEL);
    localparam logic [ADDRESS_SIZE:0]   AE_CNT    = (ADDRESS_SIZE + 1)'(AE_LEVEL);

    state_t                  state;
    state_t                  state_next;
    logic [ADDRESS_SIZE:0]   count_next;
    logic [ADDRESS_SIZE-1:0] w_ptr_next;
    logic [ADDRESS_SIZE-1:0] r_ptr_next;

    assign empty = (state == S_EMPTY);
    assign full  = (state == S_FULL);

    // The write grant is also gated by rst_n so nothing is granted while reset is held.
    assign cw_en = wr_req & ~full & rst_n;
    assign cr_en = rd_req & ~empty;

    always_comb begin
        state_next = state;
        count_next = count;
        w_ptr_next = w_ptr;
        r_ptr_next = r_ptr;

        if (cw_en) begin
            w_ptr_next = (w_ptr == LAST_PTR) ? '0 : w_ptr + 1'b1;
        end
        if (cr_en) begin
            r_ptr_next = (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
        end

        case ({cw_en, cr_en})
            2'b10:   count_next = count + ONE_CNT;
            2'b01:   count_next = count - ONE_CNT;
            default: count_next = count;
        endcase

        case (state)
            S_EMPTY: begin
                if (cw_en) begin
                    state_next = S_PART;
                end
            end
            S_PART: begin
                if (cw_en && !cr_en && count == DEPTH_M1) begin
                    state_next = S_FULL;
                end else if (cr_en && !cw_en && count == ONE_CNT) begin
                    state_next = S_EMPTY;
                end
            end
            S_FULL: begin
                if (cr_en) begin
                    state_next = S_PART;
                end
            end
            default: state_next = S_EMPTY;
        endcase
    end

    // Status flags are registered from the next occupancy so they line up with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_EMPTY;
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            state        <= state_next;
            w_ptr        <= w_ptr_next;
            r_ptr        <= r_ptr_next;
            count        <= count_next;
            almost_full  <= (count_next >= AF_CNT);
            almost_empty <= (count_next <= AE_CNT);
        end
    end

    // Sticky errors: a new violation wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a behavioural occupancy model pushes expected
// post-edge results into a scoreboard queue that is popped after each clock edge.
module tb_fifo_ctrl;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       wr_req;
    logic       rd_req;
    logic       clr_err;
    logic       cw_en;
    logic       cr_en;
    logic [1:0] w_ptr;
    logic [1:0] r_ptr;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    typedef struct {
        int w_ptr;
        int r_ptr;
        int count;
        int af;
        int ae;
        int ovf;
        int udf;
    } exp_t;

    exp_t exp_q[$];

    int vectors;
    int miscompares;

    int m_w;
    int m_r;
    int m_count;
    int m_ovf;
    int m_udf;

    fifo_ctrl #(
        .MEMORY_DEPTH(DEPTH),
        .ADDRESS_SIZE(2),
        .AF_LEVEL(DEPTH - 1),
        .AE_LEVEL(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_req(wr_req),
        .rd_req(rd_req),
        .clr_err(clr_err),
        .cw_en(cw_en),
        .cr_en(cr_en),
        .w_ptr(w_ptr),
        .r_ptr(r_ptr),
        .count(count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        m_w     = 0;
        m_r     = 0;
        m_count = 0;
        m_ovf   = 0;
        m_udf   = 0;
        exp_q.delete();
    endtask

    // Called while rst_n is low: every output must sit at its reset value.
    task automatic checkReset(input string tag);
        wr_req = 1'b1;
        rd_req = 1'b1;
        #1;
        checkOutput({tag, ".cw_en"}, int'(cw_en), 0);
        checkOutput({tag, ".cr_en"}, int'(cr_en), 0);
        checkOutput({tag, ".w_ptr"}, int'(w_ptr), 0);
        checkOutput({tag, ".r_ptr"}, int'(r_ptr), 0);
        checkOutput({tag, ".count"}, int'(count), 0);
        checkOutput({tag, ".empty"}, int'(empty), 1);
        checkOutput({tag, ".full"}, int'(full), 0);
        checkOutput({tag, ".almost_empty"}, int'(almost_empty), 1);
        checkOutput({tag, ".almost_full"}, int'(almost_full), 0);
        checkOutput({tag, ".overflow"}, int'(overflow), 0);
        checkOutput({tag, ".underflow"}, int'(underflow), 0);
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic popAndCheck();
        exp_t e;
        checkOutput("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("w_ptr", int'(w_ptr), e.w_ptr);
            checkOutput("r_ptr", int'(r_ptr), e.r_ptr);
            checkOutput("count", int'(count), e.count);
            checkOutput("full", int'(full), int'(e.count == DEPTH));
            checkOutput("empty", int'(empty), int'(e.count == 0));
            checkOutput("almost_full", int'(almost_full), e.af);
            checkOutput("almost_empty", int'(almost_empty), e.ae);
            checkOutput("overflow", int'(overflow), e.ovf);
            checkOutput("underflow", int'(underflow), e.udf);
        end
    endtask

    // Drives one cycle of requests, checks the same-cycle grants and queues the
    // expected registered results, then checks them after the edge.
    task automatic applyStimulus(input logic wr, input logic rd, input logic clr);
        int   g_w;
        int   g_r;
        exp_t e;
        @(negedge clk);
        wr_req  = wr;
        rd_req  = rd;
        clr_err = clr;
        #1;
        g_w = (wr && m_count != DEPTH) ? 1 : 0;
        g_r = (rd && m_count != 0) ? 1 : 0;
        checkOutput("cw_en", int'(cw_en), g_w);
        checkOutput("cr_en", int'(cr_en), g_r);

        if (wr && m_count == DEPTH) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (rd && m_count == 0) m_udf = 1;
        else if (clr) m_udf = 0;
        m_count = m_count + g_w - g_r;
        if (g_w == 1) m_w = (m_w + 1) % DEPTH;
        if (g_r == 1) m_r = (m_r + 1) % DEPTH;

        e.w_ptr = m_w;
        e.r_ptr = m_r;
        e.count = m_count;
        e.af    = (m_count >= DEPTH - 1) ? 1 : 0;
        e.ae    = (m_count <= 1) ? 1 : 0;
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        popAndCheck();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        wr_req      = 1'b0;
        rd_req      = 1'b0;
        clr_err     = 1'b0;
        resetModel();

        #12;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] fill to full");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] overflow and clear");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] drain, underflow, write then read");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] simultaneous requests at count 2");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);

        $display("[TB] simultaneous requests at full and empty");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 7) == 0));
        end

        $display("[TB] asynchronous reset mid-cycle at count 3");
        applyStimulus(1'b0, 1'b0, 1'b1);
        while (m_count < 3) applyStimulus(1'b1, 1'b0, 1'b0);
        while (m_count > 3) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pre_reset_count", int'(count), 3);
        wr_req = 1'b0;
        rd_req = 1'b0;
        #2;
        rst_n = 1'b0;
        checkReset("async_reset");
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 4, number of FIFO entries (2..2**ADDRESS_SIZE).
REQ-002 SHALL have parameter ADDRESS_SIZE, default 2, pointer width.
REQ-003 SHALL have parameter AF_LEVEL, default MEMORY_DEPTH-1, almost_full threshold (count >= AF_LEVEL).
REQ-004 SHALL have parameter AE_LEVEL, default 1, almost_empty threshold (count <= AE_LEVEL).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 wr_req  input  1  producer requests a write this cycle.
REQ-008 rd_req  input  1  consumer requests a read this cycle.
REQ-009 clr_err  input  1  synchronous clear of sticky error flags.
REQ-010 cw_en  output  1  write grant; memory write enable and write-pointer advance.
REQ-011 cr_en  output  1  read grant; read-pointer advance.
REQ-012 w_ptr  output  ADDRESS_SIZE  write address.
REQ-013 r_ptr  output  ADDRESS_SIZE  read address.
REQ-014 count  output  ADDRESS_SIZE+1  current occupancy, 0..MEMORY_DEPTH.
REQ-015 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL implement a 3-state FSM: S_EMPTY, S_PART, S_FULL; state is registered.
REQ-018 empty SHALL be 1 exactly in S_EMPTY; full SHALL be 1 exactly in S_FULL; both are decoded from registered state only.
REQ-019 cw_en SHALL be wr_req & ~full (combinational, same cycle).
REQ-020 cr_en SHALL be rd_req & ~empty (combinational, same cycle).
REQ-021 w_ptr SHALL advance by 1 on each cycle with cw_en=1 and wrap from MEMORY_DEPTH-1 to 0; r_ptr SHALL do the same on cr_en=1.
REQ-022 count SHALL update next edge: +1 on cw_en only, -1 on cr_en only, unchanged on both or neither.
REQ-023 Transitions: S_EMPTY -> S_FULL when cw_en and MEMORY_DEPTH=... not applicable; S_EMPTY -> S_PART on cw_en (MEMORY_DEPTH>=2).
REQ-024 S_PART -> S_FULL when cw_en & ~cr_en and count = MEMORY_DEPTH-1.
REQ-025 S_PART -> S_EMPTY when cr_en & ~cw_en and count = 1.
REQ-026 S_FULL -> S_PART on cr_en; S_EMPTY and S_FULL SHALL otherwise hold.
REQ-027 Simultaneous wr_req and rd_req in S_PART SHALL grant both; count and state unchanged, both pointers advance.
REQ-028 Simultaneous requests in S_EMPTY SHALL grant write only; in S_FULL, read only.
REQ-029 almost_full SHALL be registered, equal (next count >= AF_LEVEL); almost_empty registered, equal (next count <= AE_LEVEL).
REQ-030 overflow SHALL set on the edge after wr_req=1 while full=1; underflow SHALL set on the edge after rd_req=1 while empty=1.
REQ-031 Error flags SHALL hold until clr_err=1; set condition in the same cycle as clr_err SHALL win.
REQ-032 Invariant: count = (w_ptr - r_ptr) mod MEMORY_DEPTH, except count=MEMORY_DEPTH when full (pointers equal).

Reset
REQ-033 rst_n=0 SHALL immediately force: state S_EMPTY, w_ptr=0, r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-034 During reset cw_en and cr_en SHALL be 0 regardless of requests (empty=1 blocks reads; write grant gated by rst_n).
REQ-035 Reset asserted mid-operation SHALL discard all occupancy; first cycle after release behaves as post-reset empty.

Verification
REQ-036 Reset, then 4 writes (depth 4) -> w_ptr 1,2,3,0; count 1..4; full=1 after 4th; almost_full=1 at count 3.
REQ-037 From full, wr_req=1 one cycle -> cw_en=0, count stays 4, overflow=1 next cycle; clr_err pulse -> overflow=0.
REQ-038 From empty, rd_req=1 -> cr_en=0, underflow=1; write then read -> r_ptr 0->1, empty=1 again, count 0.
REQ-039 Count 2, wr_req=rd_req=1 for 3 cycles -> both grants each cycle, count stays 2, pointers wrap through 0.
REQ-040 Full with wr_req=rd_req=1 -> only cr_en=1, count 3, state S_PART; empty with both -> only cw_en=1, count 1.
REQ-041 rst_n pulsed low asynchronously (mid-cycle) at count 3 -> all outputs at reset values before next clk edge.
